// File: rtl/addac_pkg.sv
// rtl/addac_pkg.sv - shared types and opcode decode for the addac bit-serial sequencer.
package addac_pkg;

    typedef enum logic [1:0] {
        OP_LOAD  = 2'b00,
        OP_LOADN = 2'b01,
        OP_ADD   = 2'b10,
        OP_SUB   = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Returns {sel0, sel1, cin0}: invert-select, add-select, bit-0 carry.
    function automatic logic [2:0] op_sel(input op_t op);
        case (op)
            OP_LOAD:  return 3'b000;
            OP_LOADN: return 3'b100;
            OP_ADD:   return 3'b010;
            OP_SUB:   return 3'b111;
            default:  return 3'b010;
        endcase
    endfunction

endpackage

// File: rtl/addac.sv
// rtl/addac.sv - bit-serial add/load stage with a free-rotating, unreset accumulator word.
module addac #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic a,
    input  logic sel0,
    input  logic sel1,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic [WIDTH-1:0] r_acc;
    logic             w_b;
    logic             w_acc0;

    assign w_b    = a ^ sel0;
    assign w_acc0 = r_acc[0];
    assign s      = sel1 ? (w_acc0 ^ w_b ^ cin) : w_b;
    assign cout   = sel1 & ((w_acc0 & w_b) | (w_acc0 & cin) | (w_b & cin));

    // Rotates every cycle; the sequencer's phase counter keeps bit k at the LSB on phase k.
    always_ff @(posedge clk) begin
        r_acc <= {s, r_acc[WIDTH-1:1]};
    end

endmodule

// File: rtl/addac_seq_shreg.sv
// rtl/addac_seq_shreg.sv - LSB-first shift register with parallel load, used as PISO and SIPO.
module shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_shift,
    input  logic             i_sin,
    output logic             o_sout,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_din;
        end else if (i_shift) begin
            r_q <= {i_sin, r_q[WIDTH-1:1]};
        end
    end

    assign o_sout = r_q[0];
    assign o_q    = r_q;

endmodule

// File: rtl/addac_seq.sv
// rtl/addac_seq.sv - serialises an operand into addac and deserialises the sum with carry/overflow flags.
module addac_seq
    import addac_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  op_t              in_op,
    input  logic [WIDTH-1:0] in_data,
    output logic             a,
    output logic             sel0,
    output logic             sel1,
    output logic             cin,
    input  logic             s,
    input  logic             cout,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_cout,
    output logic             res_ovf
);

    localparam int            PW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(WIDTH - 1);

    state_t           r_state, w_next;
    logic [PW-1:0]    r_phase;
    op_t              r_op;
    logic             r_carry, r_cout, r_ovf;
    logic             w_last, w_accept, w_shift, w_op_bit, w_sout_unused;
    logic [2:0]       w_sel, w_in_sel;
    logic [WIDTH-1:0] w_opq_unused, w_res_q;

    assign w_last   = (r_phase == LAST);
    assign w_shift  = (r_state == SHIFT);
    assign w_accept = (r_state == IDLE) && in_valid && w_last;
    assign w_sel    = op_sel(r_op);
    assign w_in_sel = op_sel(in_op);

    shreg #(.WIDTH(WIDTH)) u_opreg (
        .clk(clk), .rst(rst), .i_load(w_accept), .i_din(in_data),
        .i_shift(w_shift), .i_sin(1'b0), .o_sout(w_op_bit), .o_q(w_opq_unused)
    );

    shreg #(.WIDTH(WIDTH)) u_resreg (
        .clk(clk), .rst(rst), .i_load(1'b0), .i_din('0),
        .i_shift(w_shift), .i_sin(s), .o_sout(w_sout_unused), .o_q(w_res_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_op    <= OP_LOAD;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_phase <= w_last ? '0 : r_phase + 1'b1;
            if (w_accept) begin
                r_op    <= in_op;
                r_carry <= w_in_sel[0];
            end else if (w_shift) begin
                r_carry <= cout;
                // r_carry here is the carry into the MSB, so cout^r_carry is signed overflow.
                if (w_last) begin
                    r_cout <= cout;
                    r_ovf  <= w_sel[1] & (cout ^ r_carry);
                end
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        a         = 1'b0;
        sel0      = 1'b0;
        sel1      = 1'b1;
        cin       = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = w_last;
                if (w_accept) w_next = SHIFT;
            end
            SHIFT: begin
                a    = w_op_bit;
                sel0 = w_sel[2];
                sel1 = w_sel[1];
                cin  = r_carry;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign res_data = w_res_q;
    assign res_cout = r_cout;
    assign res_ovf  = r_ovf;

endmodule

// File: tb/tb_addac_seq.sv
// tb/tb_addac_seq.sv - self-checking bench for addac_seq driving a real addac stage.
module tb_addac_seq;
    import addac_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         res_ready = 1'b0;
    op_t          in_op = OP_LOAD;
    logic [W-1:0] in_data = '0;
    logic         in_ready, a, sel0, sel1, cin, s, cout;
    logic         res_valid, res_cout, res_ovf;
    logic [W-1:0] res_data;

    int           n_vec = 0;
    int           n_err = 0;
    int           tb_phase = 0;
    int           last_wait = 0;
    logic [W-1:0] m_acc = '0;
    logic [W-1:0] got_res;
    logic         got_cout, got_ovf;

    addac_seq #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_data(in_data), .a(a), .sel0(sel0), .sel1(sel1),
        .cin(cin), .s(s), .cout(cout), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_cout(res_cout), .res_ovf(res_ovf)
    );

    addac #(.WIDTH(W)) u_addac (
        .clk(clk), .a(a), .sel0(sel0), .sel1(sel1), .cin(cin), .s(s), .cout(cout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_phase <= rst ? 0 : (tb_phase + 1) % W;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic exp_cin(input op_t op, input logic [W-1:0] acc,
                                     input logic [W-1:0] d, input int k);
        int mask, b, c0;
        if (op == OP_LOAD || op == OP_LOADN) return 1'b0;
        mask = (1 << k) - 1;
        b    = (op == OP_SUB) ? ((~d) & 8'hFF) : int'(d);
        c0   = (op == OP_SUB) ? 1 : 0;
        return ((((int'(acc) & mask) + (b & mask) + c0) >> k) & 1) != 0;
    endfunction

    // Offers op/d and returns at the negedge of shift cycle 0 (or flags a timeout).
    task automatic wait_accept(input op_t op, input logic [W-1:0] d, output bit ok);
        int waited;
        ok = 0;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        while (waited <= 2 * W) begin
            chk("ready_phase", in_ready, (tb_phase == W - 1));
            if (in_ready === 1'b1) break;
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        last_wait = waited;
        if (waited > 2 * W) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        in_op    = op_t'($urandom_range(0, 3));
        ok = 1;
    endtask

    task automatic run_op(input op_t op, input logic [W-1:0] d, input int hold);
        logic [W-1:0] e_res;
        logic         e_c, e_o;
        int           sum, sr;
        bit           ok;
        e_c = 0;
        e_o = 0;
        case (op)
            OP_LOAD:  e_res = d;
            OP_LOADN: e_res = ~d;
            OP_ADD: begin
                sum = int'(m_acc) + int'(d);
                sr  = int'($signed(m_acc)) + int'($signed(d));
                e_res = W'(sum); e_c = (sum >= 256); e_o = (sr > 127 || sr < -128);
            end
            default: begin
                sum = int'(m_acc) + (255 - int'(d)) + 1;
                sr  = int'($signed(m_acc)) - int'($signed(d));
                e_res = W'(sum); e_c = (sum >= 256); e_o = (sr > 127 || sr < -128);
            end
        endcase
        wait_accept(op, d, ok);
        if (!ok) return;
        for (int k = 0; k < W; k++) begin
            chk("shift_a", a, d[k]);
            chk("shift_sel", {sel0, sel1}, {(op == OP_LOADN || op == OP_SUB), (op == OP_ADD || op == OP_SUB)});
            chk("shift_cin", cin, exp_cin(op, m_acc, d, k));
            chk("shift_noval", {in_ready, res_valid}, 2'b00);
            @(posedge clk);
            @(negedge clk);
        end
        chk("res_valid", res_valid, 1'b1);
        chk("res_data", res_data, e_res);
        chk("res_flags", {res_cout, res_ovf}, {e_c, e_o});
        chk("done_hold_enc", {in_ready, a, sel0, sel1, cin}, 5'b00010);
        got_res = res_data; got_cout = res_cout; got_ovf = res_ovf;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_stable", {res_valid, res_data, res_cout, res_ovf}, {1'b1, e_res, e_c, e_o});
            chk("hold_enc", {in_ready, a, sel0, sel1, cin}, 5'b00010);
        end
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("res_consumed", res_valid, 1'b0);
        m_acc = e_res;
    endtask

    initial begin
        bit ok;
        int guard;
        op_t rop;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctl", {in_ready, a, sel0, sel1, cin, res_valid, res_cout, res_ovf}, 8'b0001_0000);
        chk("reset_data", res_data, 8'h00);
        rst = 1'b0;

        run_op(OP_LOAD, 8'h5A, 0);
        chk("load5a", {got_res, got_cout, got_ovf}, {8'h5A, 2'b00});

        run_op(OP_LOAD, 8'h7F, 0);
        run_op(OP_ADD, 8'h01, 0);
        chk("add7f_01", {got_res, got_cout, got_ovf}, {8'h80, 2'b01});

        run_op(OP_LOAD, 8'h05, 0);
        run_op(OP_SUB, 8'h07, 0);
        chk("sub05_07", {got_res, got_cout, got_ovf}, {8'hFE, 2'b00});

        run_op(OP_LOAD, 8'hFF, 0);
        run_op(OP_ADD, 8'h01, 0);
        chk("addff_01", {got_res, got_cout, got_ovf}, {8'h00, 2'b10});

        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (tb_phase != 2 && guard < 2 * W);
        run_op(OP_LOADN, 8'h96, 0);
        chk("wait_from_ph3", last_wait, 4);
        chk("loadn96", got_res, 8'h69);

        run_op(OP_LOAD, 8'h3C, 0);
        run_op(OP_ADD, 8'h11, 5);
        run_op(OP_ADD, 8'h00, 0);
        chk("add0_keeps", got_res, 8'h4D);

        run_op(OP_LOAD, 8'h10, 0);
        wait_accept(OP_ADD, 8'h22, ok);
        if (ok) begin
            repeat (4) begin
                @(posedge clk);
                @(negedge clk);
            end
            rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rst = 1'b0;
            chk("abort_ctl", {in_ready, a, sel0, sel1, cin, res_valid, res_cout, res_ovf}, 8'b0001_0000);
            chk("abort_data", res_data, 8'h00);
            guard = 0;
            for (int c = 0; c < 2 * W; c++) begin
                @(negedge clk);
                if (res_valid !== 1'b0) guard++;
            end
            chk("abort_no_result", guard, 0);
        end

        for (int i = 0; i < 24; i++) begin
            rop = (i == 0) ? OP_LOAD : op_t'($urandom_range(0, 3));
            run_op(rop, W'($urandom), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/addac_seq.md
# addac_seq

Bit-serial sequencer feeding the `addac` stage. It accepts a parallel operand and an opcode over a valid/ready handshake. It then streams the operand LSB-first into `addac` together with per-cycle `sel0`/`sel1`/`cin` and a registered carry loop. It deserializes the returned `s` stream into a parallel result with carry-out and signed-overflow flags.

## Interface

Parameters:
- `WIDTH`, default 8, operand/result width in bits. Must be ≥ 2.

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operand/opcode offered
- `in_ready`  out  1  operand accepted when `in_valid && in_ready`
- `in_op`  in  2  opcode, type `op_t`
- `in_data`  in  WIDTH  operand
- `a`  out  1  serial operand bit to `addac`
- `sel0`  out  1  invert-select to `addac`
- `sel1`  out  1  add/pass-select to `addac`
- `cin`  out  1  carry-in to `addac`
- `s`  in  1  serial sum bit from `addac`
- `cout`  in  1  carry-out from `addac`
- `res_valid`  out  1  result available
- `res_ready`  in  1  result consumed when `res_valid && res_ready`
- `res_data`  out  WIDTH  result word
- `res_cout`  out  1  final carry-out
- `res_ovf`  out  1  signed overflow

## Operation

- Opcodes and per-shift-cycle drive:
  - OP_LOAD: `sel0=0`, `sel1=0`. The accumulator loads the operand.
  - OP_LOADN: `sel0=1`, `sel1=0`. The accumulator loads the inverted operand.
  - OP_ADD: `sel0=0`, `sel1=1`, bit-0 carry 0.
  - OP_SUB: `sel0=1`, `sel1=1`, bit-0 carry 1 (two's complement).
- `cin` is driven from a carry register. It is loaded with the bit-0 carry at accept, then `carry <= cout` on every shift cycle.
- Hold encoding is `a=0`, `sel0=0`, `sel1=1`, `cin=0`. It is driven in every non-shift cycle. The `addac` accumulator word recirculates unchanged, since adding 0 with carry 0 never propagates.
- Free-running `phase` counter runs modulo WIDTH. It increments every cycle and is reset to 0. This keeps `addac` bit alignment: shift cycle k always occurs at phase k.
- FSM:
  - IDLE: `in_ready = (phase == WIDTH-1)`. On handshake, latch `in_data` into the operand shift register, latch `in_op`, preload the carry register, and go to SHIFT.
  - SHIFT: lasts exactly WIDTH cycles (phase 0..WIDTH-1). Each cycle:
    - `a = opreg[0]`, then `opreg >>= 1`;
    - `resreg <= {s, resreg[WIDTH-1:1]}`;
    - capture `carry_msb <= carry` at phase WIDTH-1.
    - After phase WIDTH-1, go to DONE.
  - DONE: `res_valid=1`. Outputs `res_data`, `res_cout`, `res_ovf` are stable. On `res_ready`, go to IDLE.
- Flags:
  - `res_cout` = `cout` at the last shift cycle.
  - `res_ovf` = `cout ^ carry_msb` for ADD/SUB; 0 for LOAD/LOADN.
- The `addac` accumulator has no reset. After `rst`, the first operation must be LOAD/LOADN, or ADD/SUB results are undefined. The sequencer does not enforce this.

## Timing

- Reset values: state IDLE, `phase=0`, `in_ready=0`, `a=0`, `sel0=0`, `sel1=1`, `cin=0`, `res_valid=0`, `res_data=0`, `res_cout=0`, `res_ovf=0`.
- Accept at cycle t (phase WIDTH-1). Shift cycles run t+1..t+WIDTH. `res_valid` rises at t+WIDTH+1.
- Accept wait ranges from 0 to WIDTH-1 cycles depending on phase. Minimum spacing between accepts is 2·WIDTH cycles.
- `in_ready=0` in SHIFT and DONE. `in_valid` during those states is ignored. `res_ready` while `res_valid=0` is ignored.
- A result accepted in DONE at phase p returns to IDLE at phase p+1. An accept in that same cycle is impossible.
- `rst` in any state: next cycle equals the reset values. An in-flight result is discarded.

## Structure

- `addac_pkg` contains:
  - `op_t` enum: OP_LOAD=2'b00, OP_LOADN=2'b01, OP_ADD=2'b10, OP_SUB=2'b11;
  - `state_t` enum (IDLE, SHIFT, DONE);
  - function `op_sel(op_t) -> {sel0, sel1, cin0}`.
- One sub-module, `shreg`: parameterised WIDTH shift register with load, shift-enable, and serial in/out. It is instantiated twice, once for the operand (PISO) and once for the result (SIPO).
- The bench instantiates `addac_seq` and `addac` together.

## Test plan

All scenarios use WIDTH=8.

- Reset, then LOAD 0x5A → `a` = 0,1,0,1,1,0,1,0 on phases 0..7 with `sel1=0`; result `res_data=0x5A`, `res_cout=0`, `res_ovf=0`.
- LOAD 0x7F, then ADD 0x01 → result 0x80, `res_cout=0`, `res_ovf=1`.
- LOAD 0x05, then SUB 0x07 → result 0xFE, `res_cout=0`, `res_ovf=0`. LOAD 0xFF, then ADD 0x01 → result 0x00, `res_cout=1`, `res_ovf=0`.
- `in_valid` raised at phase 3 → `in_ready` stays 0 until phase 7, accept there, first shift at phase 0.
- `res_ready` held low 5 cycles in DONE → `res_*` stable, `in_ready=0`, hold encoding driven. A later ADD 0x00 returns the previous result unchanged.
- `rst` pulsed at shift cycle 4 of an ADD → next cycle IDLE, `phase=0`, all outputs at reset values, no `res_valid`.
